// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Serialises one outstanding access, routes responses, drops squashed fetches.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic                  if_rvalid_o,
  output logic [31:0]           if_rdata_o,
  output logic                  if_stall_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [ADDR_W-1:0]     ls_addr_i,
  input  logic [DATA_W-1:0]     ls_wdata_i,
  input  logic [DATA_W/8-1:0]   ls_wmask_i,
  output logic                  ls_rvalid_o,
  output logic [DATA_W-1:0]     ls_rdata_o,
  output logic                  ls_stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_wmask_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic                  drop_q, drop_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wmask_q, wmask_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  ls_rvalid_q, ls_rvalid_d;
  logic [31:0]           if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]     ls_rdata_q, ls_rdata_d;
  logic                  capture;
  logic                  if_ok, ls_ok;

  // A requester whose rvalid is pulsing is finishing, not asking again.
  assign if_ok = if_req_i & ~flush_i & ~if_rvalid_q;
  assign ls_ok = ls_req_i & ~ls_rvalid_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    drop_d       = drop_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    if_rvalid_d  = 1'b0;
    ls_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    capture      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_ok || ls_ok) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
          if (ls_ok && (!if_ok || last_owner_q == OWN_IF)) begin
            owner_d = OWN_LS;
            we_d    = ls_we_i;
            addr_d  = ls_addr_i;
            wdata_d = ls_wdata_i;
            wmask_d = ls_wmask_i;
          end else begin
            owner_d = OWN_IF;
            we_d    = 1'b0;
            addr_d  = if_addr_i;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      S_REQ: begin
        if (mem_ready_i) begin
          if (mem_rvalid_i) capture = 1'b1;
          else              state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) capture = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A flush coinciding with the response still squashes it.
    if (state_q != S_IDLE && owner_q == OWN_IF && flush_i) drop_d = 1'b1;

    if (capture) begin
      state_d      = S_IDLE;
      last_owner_d = owner_q;
      if (owner_q == OWN_LS) begin
        ls_rvalid_d = 1'b1;
        ls_rdata_d  = mem_rdata_i;
      end else if (!drop_d) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = mem_rdata_i[31:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      drop_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      if_rvalid_q  <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      drop_q       <= drop_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      if_rvalid_q  <= if_rvalid_d;
      ls_rvalid_q  <= ls_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = wmask_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign if_stall_o  = if_req_i & ~if_rvalid_q;
  assign ls_stall_o  = ls_req_i & ~ls_rvalid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vectors of inputs and the
// outputs expected just after the clock edge that consumed them.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_stall_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [63:0] ls_addr_i;
  logic [63:0] ls_wdata_i;
  logic [7:0]  ls_wmask_i;
  logic        ls_rvalid_o;
  logic [63:0] ls_rdata_o;
  logic        ls_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset(reset), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rvalid_o(if_rvalid_o),
    .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o), .ls_stall_o(ls_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clock = ~clock;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [63:0] Z    = 64'h0;
  localparam logic [63:0] AIF  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] AIF2 = 64'h0000_0000_8000_0040;
  localparam logic [63:0] ALS  = 64'h0000_0000_8000_1000;
  localparam logic [63:0] WD   = 64'h0000_0000_DEAD_BEEF;
  localparam logic [7:0]  WM   = 8'h0F;
  localparam logic [7:0]  Z8   = 8'h00;
  localparam logic [63:0] RD1  = 64'h0000_0000_0010_0093;
  localparam logic [63:0] D1   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2   = 64'h5555_6666_0000_0013;
  localparam logic [63:0] D3   = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] D4   = 64'h0000_0000_0040_0113;
  localparam logic [63:0] D5   = 64'h0000_0000_00A0_0193;
  localparam logic [63:0] DS   = 64'h0123_4567_89AB_CDEF;

  typedef struct {
    logic        rst, flush, ifr;
    logic [63:0] ifa;
    logic        lsr, we;
    logic [63:0] lsa, wd;
    logic [7:0]  wm;
    logic        rdy, rv;
    logic [63:0] rd;
    logic        x_req, x_we;
    logic [63:0] x_addr, x_wd;
    logic [7:0]  x_wm;
    logic        x_ifv;
    logic [31:0] x_ifd;
    logic        x_lsv;
    logic [63:0] x_lsd;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    reset        = v.rst;
    flush_i      = v.flush;
    if_req_i     = v.ifr;
    if_addr_i    = v.ifa;
    ls_req_i     = v.lsr;
    ls_we_i      = v.we;
    ls_addr_i    = v.lsa;
    ls_wdata_i   = v.wd;
    ls_wmask_i   = v.wm;
    mem_ready_i  = v.rdy;
    mem_rvalid_i = v.rv;
    mem_rdata_i  = v.rd;
    @(posedge clock);
    @(negedge clock);
    n_vec++;
    cmp("mem_req",   idx, 64'(mem_req_o),   64'(v.x_req));
    cmp("mem_we",    idx, 64'(mem_we_o),    64'(v.x_we));
    cmp("mem_addr",  idx, mem_addr_o,       v.x_addr);
    cmp("mem_wdata", idx, mem_wdata_o,      v.x_wd);
    cmp("mem_wmask", idx, 64'(mem_wmask_o), 64'(v.x_wm));
    cmp("if_rvalid", idx, 64'(if_rvalid_o), 64'(v.x_ifv));
    cmp("if_rdata",  idx, 64'(if_rdata_o),  64'(v.x_ifd));
    cmp("ls_rvalid", idx, 64'(ls_rvalid_o), 64'(v.x_lsv));
    cmp("ls_rdata",  idx, ls_rdata_o,       v.x_lsd);
    cmp("if_stall",  idx, 64'(if_stall_o),  64'(v.ifr & ~v.x_ifv));
    cmp("ls_stall",  idx, 64'(ls_stall_o),  64'(v.lsr & ~v.x_lsv));
  endtask

  vec_t tbl[28];

  initial begin
    // reset
    tbl[0]  = '{H,L,L,Z,   L,L,Z,  Z, Z8,L,L,Z,   L,L,Z,  Z, Z8,L,32'h0,       L,Z};
    tbl[1]  = '{H,L,L,Z,   L,L,Z,  Z, Z8,L,L,Z,   L,L,Z,  Z, Z8,L,32'h0,       L,Z};
    // single fetch, zero wait
    tbl[2]  = '{L,L,H,AIF, L,L,Z,  Z, Z8,L,L,Z,   H,L,AIF,Z, Z8,L,32'h0,       L,Z};
    tbl[3]  = '{L,L,H,AIF, L,L,Z,  Z, Z8,H,H,RD1, L,L,AIF,Z, Z8,H,32'h0010_0093,L,Z};
    tbl[4]  = '{L,L,L,Z,   L,L,Z,  Z, Z8,L,L,Z,   L,L,AIF,Z, Z8,L,32'h0010_0093,L,Z};
    // store, ready 3 cycles late, rvalid 2 cycles after ready
    tbl[5]  = '{L,L,L,Z,   H,H,ALS,WD,WM,L,L,Z,   H,H,ALS,WD,WM,L,32'h0010_0093,L,Z};
    tbl[6]  = '{L,L,L,Z,   H,H,ALS,WD,WM,L,L,Z,   H,H,ALS,WD,WM,L,32'h0010_0093,L,Z};
    tbl[7]  = '{L,L,L,Z,   H,H,ALS,WD,WM,L,L,Z,   H,H,ALS,WD,WM,L,32'h0010_0093,L,Z};
    tbl[8]  = '{L,L,L,Z,   H,H,ALS,WD,WM,L,L,Z,   H,H,ALS,WD,WM,L,32'h0010_0093,L,Z};
    tbl[9]  = '{L,L,L,Z,   H,H,ALS,WD,WM,H,L,Z,   L,H,ALS,WD,WM,L,32'h0010_0093,L,Z};
    tbl[10] = '{L,L,L,Z,   H,H,ALS,WD,WM,L,L,Z,   L,H,ALS,WD,WM,L,32'h0010_0093,L,Z};
    tbl[11] = '{L,L,L,Z,   H,H,ALS,WD,WM,L,H,DS,  L,H,ALS,WD,WM,L,32'h0010_0093,H,DS};
    tbl[12] = '{L,L,L,Z,   L,L,Z,  Z, Z8,L,L,Z,   L,H,ALS,WD,WM,L,32'h0010_0093,L,DS};
    // stray rvalid in IDLE is ignored
    tbl[13] = '{L,L,L,Z,   L,L,Z,  Z, Z8,L,H,D3,  L,H,ALS,WD,WM,L,32'h0010_0093,L,DS};
    // contention after reset: LS, IF, LS, IF
    tbl[14] = '{H,L,L,Z,   L,L,Z,  Z, Z8,L,L,Z,   L,L,Z,  Z, Z8,L,32'h0,       L,Z};
    tbl[15] = '{L,L,H,AIF, H,L,ALS,Z, Z8,L,L,Z,   H,L,ALS,Z, Z8,L,32'h0,       L,Z};
    tbl[16] = '{L,L,H,AIF, H,L,ALS,Z, Z8,H,H,D1,  L,L,ALS,Z, Z8,L,32'h0,       H,D1};
    tbl[17] = '{L,L,H,AIF, H,L,ALS,Z, Z8,L,L,Z,   H,L,AIF,Z, Z8,L,32'h0,       L,D1};
    tbl[18] = '{L,L,H,AIF, H,L,ALS,Z, Z8,H,H,D2,  L,L,AIF,Z, Z8,H,32'h0000_0013,L,D1};
    tbl[19] = '{L,L,H,AIF, H,L,ALS,Z, Z8,L,L,Z,   H,L,ALS,Z, Z8,L,32'h0000_0013,L,D1};
    tbl[20] = '{L,L,H,AIF, H,L,ALS,Z, Z8,H,H,D3,  L,L,ALS,Z, Z8,L,32'h0000_0013,H,D3};
    tbl[21] = '{L,L,H,AIF, H,L,ALS,Z, Z8,L,L,Z,   H,L,AIF,Z, Z8,L,32'h0000_0013,L,D3};
    tbl[22] = '{L,L,H,AIF, H,L,ALS,Z, Z8,H,H,D4,  L,L,AIF,Z, Z8,H,32'h0040_0113,L,D3};
    // flush in the grant cycle blocks the grant for that cycle only
    tbl[23] = '{L,L,L,Z,   L,L,Z,  Z, Z8,L,L,Z,   L,L,AIF,Z, Z8,L,32'h0040_0113,L,D3};
    tbl[24] = '{L,H,H,AIF2,L,L,Z,  Z, Z8,L,L,Z,   L,L,AIF,Z, Z8,L,32'h0040_0113,L,D3};
    tbl[25] = '{L,L,H,AIF2,L,L,Z,  Z, Z8,L,L,Z,   H,L,AIF2,Z,Z8,L,32'h0040_0113,L,D3};
    tbl[26] = '{L,L,H,AIF2,L,L,Z,  Z, Z8,H,H,D5,  L,L,AIF2,Z,Z8,H,32'h00A0_0193,L,D3};
    tbl[27] = '{L,L,L,Z,   L,L,Z,  Z, Z8,L,L,Z,   L,L,AIF2,Z,Z8,L,32'h00A0_0193,L,D3};

    for (int i = 0; i < 28; i++) run(tbl[i], i);

    // flush during WAIT: response discarded, next fetch completes normally
    run('{L,L,H,AIF, L,L,Z,  Z, Z8,L,L,Z,   H,L,AIF, Z, Z8,L,32'h00A0_0193,L,D3}, 100);
    run('{L,L,H,AIF, L,L,Z,  Z, Z8,H,L,Z,   L,L,AIF, Z, Z8,L,32'h00A0_0193,L,D3}, 101);
    run('{L,H,H,AIF, L,L,Z,  Z, Z8,L,L,Z,   L,L,AIF, Z, Z8,L,32'h00A0_0193,L,D3}, 102);
    run('{L,L,H,AIF2,L,L,Z,  Z, Z8,L,H,D1,  L,L,AIF, Z, Z8,L,32'h00A0_0193,L,D3}, 103);
    run('{L,L,H,AIF2,L,L,Z,  Z, Z8,L,L,Z,   H,L,AIF2,Z, Z8,L,32'h00A0_0193,L,D3}, 104);
    run('{L,L,H,AIF2,L,L,Z,  Z, Z8,H,H,D2,  L,L,AIF2,Z, Z8,H,32'h0000_0013,L,D3}, 105);
    run('{L,L,L,Z,   L,L,Z,  Z, Z8,L,L,Z,   L,L,AIF2,Z, Z8,L,32'h0000_0013,L,D3}, 106);

    // reset while in WAIT, late response after release is ignored
    run('{L,L,L,Z,   H,H,ALS,WD,WM,L,L,Z,   H,H,ALS,WD, WM,L,32'h0000_0013,L,D3}, 200);
    run('{L,L,L,Z,   H,H,ALS,WD,WM,H,L,Z,   L,H,ALS,WD, WM,L,32'h0000_0013,L,D3}, 201);
    run('{H,L,L,Z,   L,L,Z,  Z, Z8,L,L,Z,   L,L,Z,  Z,  Z8,L,32'h0,        L,Z},  202);
    run('{L,L,L,Z,   L,L,Z,  Z, Z8,L,L,Z,   L,L,Z,  Z,  Z8,L,32'h0,        L,Z},  203);
    run('{L,L,L,Z,   L,L,Z,  Z, Z8,L,H,D3,  L,L,Z,  Z,  Z8,L,32'h0,        L,Z},  204);
    run('{L,L,L,Z,   L,L,Z,  Z, Z8,L,L,Z,   L,L,Z,  Z,  Z8,L,32'h0,        L,Z},  205);
    run('{L,L,L,Z,   H,L,ALS,Z, Z8,L,L,Z,   H,L,ALS,Z,  Z8,L,32'h0,        L,Z},  206);
    run('{L,L,L,Z,   H,L,ALS,Z, Z8,H,H,D4,  L,L,ALS,Z,  Z8,L,32'h0,        H,D4}, 207);
    run('{L,L,L,Z,   L,L,Z,  Z, Z8,L,L,Z,   L,L,ALS,Z,  Z8,L,32'h0,        L,D4}, 208);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction-fetch path and the load/store unit of the rv64IM core. It owns the one shared memory port, serialises accesses with one transaction outstanding, and returns responses to the correct requester. It also generates the stall signals that freeze the fetch PC and the load/store stage, and discards fetch responses squashed by a branch flush.

## Interface
- ADDR_W, 64, address width of all address ports
- DATA_W, 64, data width of the load/store and memory data ports
- clock  in  1  clock; synchronous, active-high reset on `reset`
- reset  in  1  synchronous, active-high; returns FSM to IDLE
- flush_i  in  1  branch redirect; squashes the fetch transaction pending or in flight
- if_req_i  in  1  fetch request, held until if_rvalid_o
- if_addr_i  in  ADDR_W  fetch address (PC)
- if_rvalid_o  out  1  one-cycle pulse, if_rdata_o valid
- if_rdata_o  out  32  instruction, = mem_rdata_i[31:0]
- if_stall_o  out  1  = if_req_i & ~if_rvalid_o; drives fetch stall
- ls_req_i  in  1  load/store request, held until ls_rvalid_o
- ls_we_i  in  1  1 = store
- ls_addr_i  in  ADDR_W  data address
- ls_wdata_i  in  DATA_W  store data
- ls_wmask_i  in  DATA_W/8  byte write enables
- ls_rvalid_o  out  1  one-cycle pulse: load data valid or store acknowledged
- ls_rdata_o  out  DATA_W  load data
- ls_stall_o  out  1  = ls_req_i & ~ls_rvalid_o
- mem_req_o  out  1  request valid, payload stable while high
- mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o  out  as ls_*  latched payload
- mem_ready_i  in  1  memory accepts request this cycle
- mem_rvalid_i  in  1  response (read data or write ack) this cycle
- mem_rdata_i  in  DATA_W  read data

## Operation
- FSM states are IDLE, REQ and WAIT. Registers: owner (IF/LS), last_owner, drop flag, and the payload.
- IDLE: if any request, select owner, latch payload, clear drop, go to REQ.
  - If only one requester is active, it wins.
  - If both are active, LS wins unless last_owner == LS, in which case IF wins. LS cannot starve fetch.
  - An IF request seen with flush_i high in the same cycle is not granted.
  - For an IF grant: mem_we_o = 0, mem_wmask_o = 0, mem_wdata_o = 0.
- REQ: mem_req_o = 1.
  - mem_ready_i & mem_rvalid_i: capture the response and go to IDLE.
  - mem_ready_i only: go to WAIT.
  - Otherwise: hold REQ with the payload unchanged.
- WAIT: mem_rvalid_i captures the response and the FSM goes to IDLE. Otherwise it holds.
- mem_rvalid_i is ignored in IDLE.
- Response capture: the next cycle, the owner's rvalid_o pulses for 1 cycle, its rdata register loads mem_rdata_i, and last_owner is set to owner.
- Flush: flush_i while owner == IF in REQ or WAIT sets drop. The bus transaction still completes (no abort). When drop == 1, if_rvalid_o is suppressed and if_rdata_o is not updated. flush_i has no effect on LS transactions.
- Reset (including mid-transaction): state = IDLE, last_owner = IF, drop = 0, and all outputs are 0. A memory response arriving after reset is ignored.

## Timing
- Reset values: mem_req_o = 0, if_rvalid_o = 0, ls_rvalid_o = 0, if_rdata_o = 0, ls_rdata_o = 0, mem_* payload = 0.
- Arbitration latency is 1 cycle: a request seen in IDLE at cycle t gives mem_req_o = 1 at t+1.
- Minimum transaction (ready and rvalid both in cycle t+1): rvalid_o at t+2, and a new grant is possible at t+2, so mem_req_o can be high again at t+3. Peak throughput is 1 access per 2 cycles.
- rvalid_o never pulses for a requester not currently owning the port.
- rvalid_o pulses exactly once per grant, except for a dropped IF grant, which pulses zero times.
- Stall outputs are combinational from the req input and the registered rvalid, with no other dependency.
- Requesters hold req and payload stable until their rvalid pulse; the arbiter samples the payload only at grant.

## Test plan
- **Single fetch, zero wait:**
  - Stimulus: if_req_i = 1, if_addr_i = 0x8000_0000, memory ready and rvalid in the same cycle with rdata 0x0000_0000_0010_0093.
  - Required: mem_req_o rises 1 cycle after request; if_rvalid_o pulses 2 cycles after the request with if_rdata_o = 0x0010_0093; if_stall_o is high until that pulse.
- **Store with waits:**
  - Stimulus: ls_we_i = 1, addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0x0F; ready delayed 3 cycles, rvalid 2 cycles after ready.
  - Required: payload held stable while mem_req_o is high; a single ls_rvalid_o pulse.
- **Contention fairness:**
  - Stimulus: if_req_i and ls_req_i both held high across 4 transactions.
  - Required: grant order after reset is LS, IF, LS, IF.
- **Flush in WAIT:**
  - Stimulus: IF granted, flush_i pulsed during WAIT, then rvalid arrives.
  - Required: no if_rvalid_o pulse and if_rdata_o unchanged; a new IF request at 0x8000_0040 is then granted and completes normally.
- **Reset mid-transaction:**
  - Stimulus: reset asserted in WAIT, then mem_rvalid_i arrives 1 cycle after reset is released.
  - Required: all outputs 0; no rvalid pulse; the next request starts from IDLE.
- **Flush in the grant cycle:**
  - Stimulus: flush_i and if_req_i high together in IDLE, ls_req_i low.
  - Required: no grant that cycle; the grant occurs the next cycle if if_req_i is still high.
